// File: rtl/uart_pkg.sv
// Shared UART constants, derived bit-timing helper and the tx-queue pacer state encoding.
package uart_pkg;

  localparam int unsigned DEF_CLK_FREQ  = 32'd50_000_000;
  localparam int unsigned DEF_BAUD      = 32'd9600;
  localparam int unsigned DEF_FRAME_BITS = 32'd10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_GAP   = 2'd2
  } txq_state_e;

  // Clocks per UART bit, truncated.
  function automatic int unsigned bit_cycles(input int unsigned clk_freq,
                                             input int unsigned baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/txq_fifo_mem.sv
// Byte FIFO storage with wrapping read/write pointers and a separate occupancy counter.
module txq_fifo_mem #(
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [7:0]               wdata,
  output logic [7:0]               head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [CW-1:0] count_q, count_d;

  // Pointer advance and occupancy next-state.
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (push) begin
      wptr_d = wptr_q + AW'(1);
    end else begin
      wptr_d = wptr_q;
    end
    if (pop) begin
      rptr_d = rptr_q + AW'(1);
    end else begin
      rptr_d = rptr_q;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy registers; reset flushes the queue.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wptr_q] <= wdata;
    end
  end

  assign head  = mem_q[rptr_q];
  assign count = count_q;
  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == CW'(0));

endmodule

// File: rtl/uart_tx_queue.sv
// Byte queue and frame pacer feeding tx_uart with strobes at least one frame apart.
// Optional saturating drop counter enabled by defining UART_TX_QUEUE_DROPCNT_EN.
module uart_tx_queue
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ     = DEF_CLK_FREQ,
  parameter int unsigned BAUD         = DEF_BAUD,
  parameter int unsigned FRAME_BITS   = DEF_FRAME_BITS,
  parameter int unsigned GUARD_CYCLES = 32'd16,
  parameter int unsigned DEPTH        = 32'd16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [7:0]             in_data,
  input  logic                   in_valid,
  output logic [7:0]             out_data,
  output logic                   out_valid,
  output logic [$clog2(DEPTH):0] count,
  output logic                   empty,
  output logic                   full,
  output logic                   overflow,
  output logic [7:0]             drop_cnt
);

  localparam int unsigned BIT_CYC = bit_cycles(CLK_FREQ, BAUD);
  localparam int unsigned GAP     = BIT_CYC * FRAME_BITS + GUARD_CYCLES;
  localparam int unsigned GW      = $clog2(GAP + 1);

  txq_state_e    state_q, state_d;
  logic [GW-1:0] gap_q, gap_d;
  logic [7:0]    out_data_q, out_data_d;
  logic          out_valid_q, out_valid_d;
  logic          ovf_q, ovf_d;
  logic          pop_s, push_s, drop_s;
  logic [7:0]    head_s;
  logic          full_s, empty_s;

  // A full FIFO still takes a byte when the head leaves on the same edge.
  assign push_s = in_valid & (~full_s | pop_s);
  assign drop_s = in_valid & full_s & ~pop_s;

  txq_fifo_mem #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_s),
    .pop   (pop_s),
    .wdata (in_data),
    .head  (head_s),
    .count (count),
    .full  (full_s),
    .empty (empty_s)
  );

  // Pacing FSM next-state and strobe generation.
  always_comb begin
    state_d     = state_q;
    gap_d       = gap_q;
    out_valid_d = 1'b0;
    out_data_d  = out_data_q;
    pop_s       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!empty_s) state_d = ST_ISSUE;
        else          state_d = ST_IDLE;
      end
      ST_ISSUE: begin
        out_valid_d = 1'b1;
        out_data_d  = head_s;
        pop_s       = 1'b1;
        gap_d       = GW'(GAP - 1);
        state_d     = ST_GAP;
      end
      ST_GAP: begin
        if (gap_q == GW'(0)) begin
          if (!empty_s) state_d = ST_ISSUE;
          else          state_d = ST_IDLE;
        end else begin
          gap_d = gap_q - GW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign ovf_d = ovf_q | drop_s;

  // FSM, gap counter, output and sticky-overflow registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      gap_q       <= '0;
      out_data_q  <= 8'h00;
      out_valid_q <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      gap_q       <= gap_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      ovf_q       <= ovf_d;
    end
  end

`ifdef UART_TX_QUEUE_DROPCNT_EN
  logic [7:0] drop_q, drop_d;

  // Saturating count of dropped pushes.
  always_comb begin
    drop_d = drop_q;
    if (drop_s && (drop_q != 8'hFF)) drop_d = drop_q + 8'd1;
    else                             drop_d = drop_q;
  end

  // Drop counter register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) drop_q <= 8'h00;
    else      drop_q <= drop_d;
  end

  assign drop_cnt = drop_q;
`else
  assign drop_cnt = 8'h00;
`endif

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign empty     = empty_s;
  assign full      = full_s;
  assign overflow  = ovf_q;

endmodule

// File: doc/uart_tx_queue.md
# uart_tx_queue

Byte queue and frame pacer between `ctrl_uart` and `tx_uart`. It accepts one-cycle byte strobes from the controller, buffers them in a FIFO, and re-issues them to `tx_uart` as one-cycle strobes. Issued strobes are spaced at least one full UART frame apart, so back-to-back reply bytes are never lost. The block runs in the 50 MHz `clk` domain; the UART defaults are 9600 baud, 8N1.

## Interface
Parameters:
- `CLK_FREQ`, 50_000_000: clock frequency in Hz.
- `BAUD`, 9600: line rate.
- `FRAME_BITS`, 10: bits per frame (start + 8 data + stop).
- `GUARD_CYCLES`, 16: extra idle clocks added after each frame.
- `DEPTH`, 16: FIFO entries; must be a power of two, ≥ 2.

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  reset; asynchronous, active-low.
- `in_data`  in  8  byte from `ctrl_uart`.
- `in_valid`  in  1  one-cycle push strobe.
- `out_data`  out  8  byte to `tx_uart.tx_data`.
- `out_valid`  out  1  one-cycle strobe to `tx_uart.tx_ready`.
- `count`  out  $clog2(DEPTH)+1  current occupancy.
- `empty`  out  1  high when `count == 0`.
- `full`  out  1  high when `count == DEPTH`.
- `overflow`  out  1  sticky flag: a byte was dropped.
- `drop_cnt`  out  8  number of dropped bytes (see Configuration).

## Operation
- `BIT_CYCLES = CLK_FREQ / BAUD`, using integer truncation (5208 at the defaults).
- `GAP = BIT_CYCLES * FRAME_BITS + GUARD_CYCLES` (52096 at the defaults).
- Push: on a `clk` edge with `in_valid == 1`, the byte is written at the write pointer and the write pointer is incremented modulo `DEPTH`.
  - The push is accepted if the FIFO is not full, or if a pop occurs in the same cycle.
  - Otherwise the byte is dropped and `overflow` is set. `overflow` is cleared only by reset.
- Pointers are `$clog2(DEPTH)` bits wide and wrap naturally. `count` is a separate up/down counter:
  - push only: +1; pop only: -1; push and pop together: unchanged.
- State machine, with states IDLE, ISSUE and GAP:
  - IDLE: if `!empty`, go to ISSUE; otherwise stay.
  - ISSUE (one cycle): drive `out_valid = 1`, drive `out_data` = head entry, pop, load the gap counter with `GAP-1`, go to GAP.
  - GAP: decrement the counter; at 0, go to ISSUE if `!empty`, else IDLE.
- `out_data` is registered and holds the last issued byte between strobes.
- A push and a pop in the same cycle on an empty FIFO cannot happen, because ISSUE is entered only when the FIFO is non-empty.
- Reset mid-frame flushes the queue and returns to IDLE. `tx_uart` shares `rst`, so the wire-level frame in flight is aborted consistently.

## Timing
- Reset values:
  - `out_data = 8'h00`, `out_valid = 0`
  - `count = 0`, `empty = 1`, `full = 0`
  - `overflow = 0`, `drop_cnt = 0`
  - state IDLE, pointers 0
- Latency: with the block in IDLE and the FIFO empty, `in_valid` sampled at edge n gives `out_valid` high for the cycle after edge n+2.
- Consecutive `out_valid` pulses are exactly `GAP + 1` cycles apart while data is queued.
- `count`, `empty` and `full` update on the same edge as the push or pop that changes them.
- `out_valid` is never high on two consecutive cycles.

## Configuration
- `UART_TX_QUEUE_DROPCNT_EN`:
  - Defined: `drop_cnt` is an 8-bit counter that increments on every dropped push and saturates at 255.
  - Undefined: `drop_cnt` is tied to `8'h00`, and no counter logic is synthesised.
- `overflow` behaves identically in both cases.

## Structure
- Shared package `uart_pkg` holds:
  - the defaults for `CLK_FREQ`, `BAUD` and `FRAME_BITS`;
  - the derived `BIT_CYCLES` function;
  - the state encoding: IDLE=2'd0, ISSUE=2'd1, GAP=2'd2.
- Sub-module `txq_fifo_mem` holds the storage array plus the pointer and count logic, and exposes `push`, `pop`, `head`, `count`, `full` and `empty`.
- `uart_tx_queue` adds the pacing FSM, the gap counter and the drop logic.

## Test plan
- Reset: hold `rst = 0` and drive `in_valid` pulses -> all outputs stay at their reset values; after release, `empty = 1`.
- Single byte: push `8'h73` at cycle n -> `out_valid` pulse with `out_data = 8'h73` at n+3, then `empty = 1`.
- Burst: push `8'h73`, `8'h03`, `8'h74`, `8'h00` on four consecutive cycles -> four strobes, in order, spaced 52097 cycles apart; `count` peaks at 3.
- Overflow: with `DEPTH = 16` and the block in GAP, push 18 bytes -> `full = 1`, `overflow = 1`; `drop_cnt = 2` with the macro defined, 0 without it.
- Full with simultaneous pop: fill to 16 and push in the ISSUE cycle -> byte accepted, `count` stays 16, `overflow` stays 0.
- Reset mid-gap: assert `rst` low with 5 bytes queued -> `count = 0` immediately, and no further `out_valid` pulses after release.
- End-to-end with `tx_uart`: the serial line shows 4 clean 8N1 frames for the burst, decoded back to `8'h73`, `8'h03`, `8'h74`, `8'h00`.
